alu16_seq: RTL and testbench

- Multi-cycle sequencer for the 16-bit arithmetic ops: ADD HL,rr; ADD SP,e (also used for LD HL,SP+e); INC rr; DEC rr.
- Sits directly upstream of the 8-bit ALU. Drives the ALU operand, opcode and flag-input ports, and consumes its result and flag outputs.
- Runs two byte passes: low byte first, then high byte with the pass-1 carry/borrow chained in.
- Hands the 16-bit result and the final flags to register-file writeback.

---
 rtl/alu16_seq_if.sv | 31 +++
 rtl/alu16_seq.sv | 202 ++++++++++++++++++++
 tb/tb_alu16_seq.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu16_seq_if.sv
// Bundle of the request, writeback and 8-bit ALU signals around alu16_seq.
// slave is the sequencer side; master is the requester plus the ALU.
interface alu16_seq_if;
    logic        start;
    logic [1:0]  op;
    logic [15:0] opa;
    logic [15:0] opb;
    logic [3:0]  flags_in;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic [3:0]  flags_out;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [4:0]  alu_op;
    logic [3:0]  alu_flags_in;
    logic [7:0]  alu_result;
    logic [3:0]  alu_flags_out;

    // Handshake: start is a one-cycle request honoured only while busy=0;
    // done pulses for one cycle, and result/flags_out are valid from that cycle on.
    modport slave (
        input  start, op, opa, opb, flags_in, alu_result, alu_flags_out,
        output busy, done, result, flags_out, alu_a, alu_b, alu_op, alu_flags_in
    );

    modport master (
        output start, op, opa, opb, flags_in, alu_result, alu_flags_out,
        input  busy, done, result, flags_out, alu_a, alu_b, alu_op, alu_flags_in
    );
endinterface

// File: rtl/alu16_seq.sv
// Two-pass 16-bit ADD HL,rr / ADD SP,e / INC rr / DEC rr sequencer in front of the 8-bit ALU.
// Optional macro ALU16_FASTINC_EN: INC16/DEC16 skip the high pass when the low pass does not carry.
module alu16_seq #(
    parameter logic [4:0] ALU_NOP_OP = 5'b11100,
    parameter logic [4:0] ALU_ADD_OP = 5'b00000,
    parameter logic [4:0] ALU_ADC_OP = 5'b00001,
    parameter logic [4:0] ALU_SUB_OP = 5'b00010,
    parameter logic [4:0] ALU_SBC_OP = 5'b00011
) (
    input  logic          clk,
    input  logic          rst_n,
    alu16_seq_if.slave    seq_io,
    output logic [1:0]    dbg_state_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam logic [1:0] OP_ADD_HL = 2'b00;
    localparam logic [1:0] OP_ADD_SP = 2'b01;
    localparam logic [1:0] OP_INC16  = 2'b10;
    localparam logic [1:0] OP_DEC16  = 2'b11;

    state_e      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [15:0] opa_q, opa_d;
    logic [15:0] opb_q, opb_d;
    logic [3:0]  fl_q, fl_d;
    logic        c1_q, c1_d;
    logic        h1_q, h1_d;
    logic [7:0]  lo_q, lo_d;
    logic [15:0] result_q, result_d;
    logic [3:0]  flags_out_q, flags_out_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [7:0]  alu_a_q, alu_a_d;
    logic [7:0]  alu_b_q, alu_b_d;
    logic [4:0]  alu_op_q, alu_op_d;
    logic [3:0]  alu_fi_q, alu_fi_d;

    logic unused_alu_zn;
    assign unused_alu_zn = ^seq_io.alu_flags_out[3:2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        fl_d        = fl_q;
        c1_d        = c1_q;
        h1_d        = h1_q;
        lo_d        = lo_q;
        result_d    = result_q;
        flags_out_d = flags_out_q;
        alu_a_d     = 8'h00;
        alu_b_d     = 8'h00;
        alu_op_d    = ALU_NOP_OP;
        alu_fi_d    = 4'h0;

        case (state_q)
            ST_IDLE: begin
                if (seq_io.start) begin
                    state_d = ST_LO;
                    op_d    = seq_io.op;
                    opa_d   = seq_io.opa;
                    opb_d   = seq_io.opb;
                    fl_d    = seq_io.flags_in;
                    alu_b_d = seq_io.opa[7:0];
                    case (seq_io.op)
                        OP_ADD_HL, OP_ADD_SP: begin
                            alu_op_d = ALU_ADD_OP;
                            alu_a_d  = seq_io.opb[7:0];
                        end
                        OP_INC16: begin
                            alu_op_d = ALU_ADD_OP;
                            alu_a_d  = 8'h01;
                        end
                        default: begin
                            alu_op_d = ALU_SUB_OP;
                            alu_a_d  = 8'h01;
                        end
                    endcase
                end
            end
            ST_LO: begin
                lo_d     = seq_io.alu_result;
                c1_d     = seq_io.alu_flags_out[0];
                h1_d     = seq_io.alu_flags_out[1];
                state_d  = ST_HI;
                // High pass chains the low-pass carry/borrow straight from the ALU.
                alu_b_d  = opa_q[15:8];
                alu_fi_d = {3'b000, seq_io.alu_flags_out[0]};
                case (op_q)
                    OP_ADD_HL: begin
                        alu_op_d = ALU_ADC_OP;
                        alu_a_d  = opb_q[15:8];
                    end
                    OP_ADD_SP: begin
                        alu_op_d = ALU_ADC_OP;
                        alu_a_d  = {8{opb_q[7]}};
                    end
                    OP_INC16: begin
                        alu_op_d = ALU_ADC_OP;
                        alu_a_d  = 8'h00;
                    end
                    default: begin
                        alu_op_d = ALU_SBC_OP;
                        alu_a_d  = 8'h00;
                    end
                endcase
`ifdef ALU16_FASTINC_EN
                if ((op_q == OP_INC16 || op_q == OP_DEC16) && !seq_io.alu_flags_out[0]) begin
                    state_d     = ST_DONE;
                    result_d    = {opa_q[15:8], seq_io.alu_result};
                    flags_out_d = fl_q;
                    alu_a_d     = 8'h00;
                    alu_b_d     = 8'h00;
                    alu_op_d    = ALU_NOP_OP;
                    alu_fi_d    = 4'h0;
                end
`endif
            end
            ST_HI: begin
                state_d  = ST_DONE;
                result_d = {seq_io.alu_result, lo_q};
                case (op_q)
                    OP_ADD_HL: flags_out_d = {fl_q[3], 1'b0, seq_io.alu_flags_out[1:0]};
                    OP_ADD_SP: flags_out_d = {2'b00, h1_q, c1_q};
                    default:   flags_out_d = fl_q;
                endcase
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q        <= 2'b00;
            opa_q       <= 16'h0000;
            opb_q       <= 16'h0000;
            fl_q        <= 4'h0;
            c1_q        <= 1'b0;
            h1_q        <= 1'b0;
            lo_q        <= 8'h00;
            result_q    <= 16'h0000;
            flags_out_q <= 4'h0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            alu_a_q     <= 8'h00;
            alu_b_q     <= 8'h00;
            alu_op_q    <= ALU_NOP_OP;
            alu_fi_q    <= 4'h0;
        end else begin
            op_q        <= op_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            fl_q        <= fl_d;
            c1_q        <= c1_d;
            h1_q        <= h1_d;
            lo_q        <= lo_d;
            result_q    <= result_d;
            flags_out_q <= flags_out_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
            alu_fi_q    <= alu_fi_d;
        end
    end

    assign seq_io.busy         = busy_q;
    assign seq_io.done         = done_q;
    assign seq_io.result       = result_q;
    assign seq_io.flags_out    = flags_out_q;
    assign seq_io.alu_a        = alu_a_q;
    assign seq_io.alu_b        = alu_b_q;
    assign seq_io.alu_op       = alu_op_q;
    assign seq_io.alu_flags_in = alu_fi_q;
    assign dbg_state_o         = state_q;

endmodule

// File: tb/tb_alu16_seq.sv
// Directed bench for alu16_seq with a behavioural 8-bit ALU hung off the interface.
module tb_alu16_seq;
    localparam logic [4:0] NOP = 5'b11100;
    localparam logic [4:0] ADD = 5'b00000;
    localparam logic [4:0] ADC = 5'b00001;
    localparam logic [4:0] SUB = 5'b00010;
    localparam logic [4:0] SBC = 5'b00011;
`ifdef ALU16_FASTINC_EN
    localparam int FAST_LAT = 2;
`else
    localparam int FAST_LAT = 3;
`endif

    logic clk;
    logic rst_n;
    logic [1:0] dbg_state;
    int n_tests;
    int n_fail;

    alu16_seq_if bus();

    alu16_seq dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seq_io      (bus.slave),
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- 8-bit ALU model ----------------
    logic [8:0] m_s;
    logic [4:0] m_h;
    logic [7:0] m_r;
    logic       m_n;
    always_comb begin
        m_s = 9'h000;
        m_h = 5'h00;
        m_n = 1'b0;
        case (bus.alu_op)
            ADD: begin
                m_s = {1'b0, bus.alu_b} + {1'b0, bus.alu_a};
                m_h = {1'b0, bus.alu_b[3:0]} + {1'b0, bus.alu_a[3:0]};
            end
            ADC: begin
                m_s = {1'b0, bus.alu_b} + {1'b0, bus.alu_a} + {8'h00, bus.alu_flags_in[0]};
                m_h = {1'b0, bus.alu_b[3:0]} + {1'b0, bus.alu_a[3:0]} + {4'h0, bus.alu_flags_in[0]};
            end
            SUB: begin
                m_s = {1'b0, bus.alu_b} - {1'b0, bus.alu_a};
                m_h = {1'b0, bus.alu_b[3:0]} - {1'b0, bus.alu_a[3:0]};
                m_n = 1'b1;
            end
            SBC: begin
                m_s = {1'b0, bus.alu_b} - {1'b0, bus.alu_a} - {8'h00, bus.alu_flags_in[0]};
                m_h = {1'b0, bus.alu_b[3:0]} - {1'b0, bus.alu_a[3:0]} - {4'h0, bus.alu_flags_in[0]};
                m_n = 1'b1;
            end
            default: m_s = {1'b0, bus.alu_a};
        endcase
        m_r = m_s[7:0];
        bus.alu_result = m_r;
        if (bus.alu_op == ADD || bus.alu_op == ADC || bus.alu_op == SUB || bus.alu_op == SBC)
            bus.alu_flags_out = {(m_r == 8'h00), m_n, m_h[4], m_s[8]};
        else
            bus.alu_flags_out = bus.alu_flags_in;
    end

    // ---------------- driver ----------------
    task automatic run_op(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                          input logic [3:0] f, output logic [15:0] r, output logic [3:0] fo,
                          output int cyc);
        @(negedge clk);
        bus.start = 1'b1; bus.op = o; bus.opa = a; bus.opb = b; bus.flags_in = f;
        @(negedge clk);
        // Scramble the request inputs to prove the operands were latched.
        bus.start = 1'b0; bus.opa = ~a; bus.opb = ~b; bus.flags_in = ~f;
        cyc = 1;
        while (bus.done !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        r = bus.result;
        fo = bus.flags_out;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        bus.start = 1'b0; bus.op = 2'b00; bus.opa = 16'h0; bus.opb = 16'h0; bus.flags_in = 4'h0;
        repeat (2) @(negedge clk);
        n_tests++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy_done: got %b%b expected 00", bus.busy, bus.done);
        end
        n_tests++;
        if (bus.result !== 16'h0000 || bus.flags_out !== 4'h0) begin
            n_fail++; $display("FAIL reset_result_flags: got %h/%b expected 0000/0000", bus.result, bus.flags_out);
        end
        n_tests++;
        if (bus.alu_op !== NOP || bus.alu_a !== 8'h00 || bus.alu_b !== 8'h00 || bus.alu_flags_in !== 4'h0) begin
            n_fail++; $display("FAIL reset_alu_drive: got op=%b a=%h b=%h fi=%b expected op=%b a=00 b=00 fi=0000",
                               bus.alu_op, bus.alu_a, bus.alu_b, bus.alu_flags_in, NOP);
        end
        n_tests++;
        if (dbg_state !== 2'd0) begin
            n_fail++; $display("FAIL reset_state: got %0d expected 0", dbg_state);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_add_hl();
        logic [15:0] r; logic [3:0] fo; int cyc;
        run_op(2'b00, 16'h0FFF, 16'h0001, 4'b1000, r, fo, cyc);
        n_tests++;
        if (r !== 16'h1000 || fo !== 4'b1010 || cyc != 3) begin
            n_fail++; $display("FAIL add_hl_half: got %h/%b lat %0d expected 1000/1010 lat 3", r, fo, cyc);
        end
        n_tests++;
        if (bus.busy !== 1'b1 || bus.alu_op !== NOP) begin
            n_fail++; $display("FAIL add_hl_done_cycle: got busy=%b op=%b expected busy=1 op=%b", bus.busy, bus.alu_op, NOP);
        end
        @(negedge clk);
        n_tests++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.result !== 16'h1000) begin
            n_fail++; $display("FAIL add_hl_after_done: got done=%b busy=%b res=%h expected 0 0 1000",
                               bus.done, bus.busy, bus.result);
        end
        run_op(2'b00, 16'h8000, 16'h8000, 4'b0000, r, fo, cyc);
        n_tests++;
        if (r !== 16'h0000 || fo !== 4'b0001 || cyc != 3) begin
            n_fail++; $display("FAIL add_hl_carry: got %h/%b lat %0d expected 0000/0001 lat 3", r, fo, cyc);
        end
    endtask

    task automatic test_add_sp();
        logic [15:0] r; logic [3:0] fo; int cyc;
        run_op(2'b01, 16'hFFF8, 16'h0008, 4'b1100, r, fo, cyc);
        n_tests++;
        if (r !== 16'h0000 || fo !== 4'b0011 || cyc != 3) begin
            n_fail++; $display("FAIL add_sp_pos: got %h/%b lat %0d expected 0000/0011 lat 3", r, fo, cyc);
        end
        run_op(2'b01, 16'h0000, 16'h00FF, 4'b1111, r, fo, cyc);
        n_tests++;
        if (r !== 16'hFFFF || fo !== 4'b0000 || cyc != 3) begin
            n_fail++; $display("FAIL add_sp_neg: got %h/%b lat %0d expected FFFF/0000 lat 3", r, fo, cyc);
        end
    endtask

    task automatic test_inc_dec_wrap();
        logic [15:0] r; logic [3:0] fo; int cyc;
        run_op(2'b10, 16'hFFFF, 16'h1234, 4'b1011, r, fo, cyc);
        n_tests++;
        if (r !== 16'h0000 || fo !== 4'b1011 || cyc != 3) begin
            n_fail++; $display("FAIL inc_wrap: got %h/%b lat %0d expected 0000/1011 lat 3", r, fo, cyc);
        end
        run_op(2'b11, 16'h0000, 16'h1234, 4'b1011, r, fo, cyc);
        n_tests++;
        if (r !== 16'hFFFF || fo !== 4'b1011 || cyc != 3) begin
            n_fail++; $display("FAIL dec_wrap: got %h/%b lat %0d expected FFFF/1011 lat 3", r, fo, cyc);
        end
    endtask

    task automatic test_back_to_back();
        int dones; logic [15:0] r;
        dones = 0; r = 16'hDEAD;
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b00; bus.opa = 16'h0001; bus.opb = 16'h0002; bus.flags_in = 4'h0;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        // Now in the high pass: this request must be dropped.
        bus.start = 1'b1; bus.op = 2'b10; bus.opa = 16'h5555;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 0) bus.start = 1'b0;
            if (bus.done === 1'b1) begin
                dones++;
                r = bus.result;
            end
        end
        n_tests++;
        if (dones != 1 || r !== 16'h0003) begin
            n_fail++; $display("FAIL busy_ignore: got %0d dones res %h expected 1 dones res 0003", dones, r);
        end
    endtask

    task automatic test_reset_mid();
        int dones;
        dones = 0;
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b00; bus.opa = 16'h1234; bus.opb = 16'h1111; bus.flags_in = 4'h0;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== 16'h0000) begin
            n_fail++; $display("FAIL reset_mid_outputs: got busy=%b done=%b res=%h expected 0 0 0000",
                               bus.busy, bus.done, bus.result);
        end
        n_tests++;
        if (bus.alu_op !== NOP || dbg_state !== 2'd0) begin
            n_fail++; $display("FAIL reset_mid_alu: got op=%b st=%0d expected op=%b st=0", bus.alu_op, dbg_state, NOP);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) dones++;
        end
        n_tests++;
        if (dones != 0 || bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid_no_done: got %0d dones busy=%b expected 0 dones busy=0", dones, bus.busy);
        end
    endtask

    task automatic test_fastinc();
        logic [15:0] r; logic [3:0] fo; int cyc;
        run_op(2'b10, 16'h12FE, 16'h0000, 4'b0100, r, fo, cyc);
        n_tests++;
        if (r !== 16'h12FF || fo !== 4'b0100 || cyc != FAST_LAT) begin
            n_fail++; $display("FAIL fast_inc_nocarry: got %h/%b lat %0d expected 12FF/0100 lat %0d", r, fo, cyc, FAST_LAT);
        end
        run_op(2'b10, 16'h12FF, 16'h0000, 4'b0100, r, fo, cyc);
        n_tests++;
        if (r !== 16'h1300 || cyc != 3) begin
            n_fail++; $display("FAIL fast_inc_carry: got %h lat %0d expected 1300 lat 3", r, cyc);
        end
        run_op(2'b11, 16'h3400, 16'h0000, 4'b0100, r, fo, cyc);
        n_tests++;
        if (r !== 16'h33FF || cyc != 3) begin
            n_fail++; $display("FAIL fast_dec_borrow: got %h lat %0d expected 33FF lat 3", r, cyc);
        end
        run_op(2'b11, 16'h3455, 16'h0000, 4'b0001, r, fo, cyc);
        n_tests++;
        if (r !== 16'h3454 || fo !== 4'b0001 || cyc != FAST_LAT) begin
            n_fail++; $display("FAIL fast_dec_noborrow: got %h/%b lat %0d expected 3454/0001 lat %0d", r, fo, cyc, FAST_LAT);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail = 0;
        test_reset();
        test_add_hl();
        test_add_sp();
        test_inc_dec_wrap();
        test_back_to_back();
        test_reset_mid();
        test_fastinc();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
